// File: rtl/iurt_pkg.sv
// Shared IURT definitions: escape protocol symbols and byte/beat types used by
// the controller, the hub bridge and the hub side.
package iurt_pkg;
  typedef logic [7:0] iurt_byte_t;

  localparam iurt_byte_t ESCAPE_SYMBOL = 8'h55;
  localparam iurt_byte_t RESET_SYMBOL  = 8'hEE;

  typedef struct packed {
    logic       vld;
    iurt_byte_t data;
  } iurt_beat_t;

  typedef enum logic {ST_IDLE, ST_ESC} esc_state_e;
endpackage

// File: rtl/iurt_fifo.sv
// Byte FIFO, first-word-fall-through, 2^ADDR_WIDTH entries. Head reads as 0 when
// empty so the output is defined straight out of reset.
module iurt_fifo
  import iurt_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  iurt_byte_t            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic                  push_ok, pop_ok;

  // level never exceeds DEPTH, so its MSB alone marks full
  assign empty   = (level == '0);
  assign full    = level[ADDR_WIDTH];
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      if (push_ok && !pop_ok)      level <= level + 1'b1;
      else if (pop_ok && !push_ok) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/iurt_hub_bridge.sv
// IPDBG hub <-> IurtController bridge: escape decoder + down FIFO, one-entry up slice.
// Define IURT_BRIDGE_OVF_COUNT_EN to add the saturating 16-bit ovf_count output.
module iurt_hub_bridge
  import iurt_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                hub_dn_valid,
  input  logic [7:0]          hub_dn_data,
  input  logic                hub_up_ready,
  output logic                hub_up_valid,
  output logic [7:0]          hub_up_data,
  input  logic                data_dwn_ready,
  output logic                data_dwn_valid,
  output logic [7:0]          data_dwn,
  input  logic                data_up_valid,
  input  logic [7:0]          data_up,
  output logic                data_up_ready,
  output logic                reset_o,
  output logic                overflow_o,
  output logic [ADDR_WIDTH:0] fill_level
`ifdef IURT_BRIDGE_OVF_COUNT_EN
  ,
  output logic [15:0]         ovf_count
`endif
);
  esc_state_e state_q, state_d;
  logic       push_req, rst_cmd;
  logic       f_push, f_pop, f_flush, f_empty, f_full, drop;
  iurt_beat_t up_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state_q <= ST_IDLE;
    else if (ce) state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    rst_cmd  = 1'b0;
    if (hub_dn_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (hub_dn_data == ESCAPE_SYMBOL) state_d = ST_ESC;
          else                              push_req = 1'b1;
        end
        ST_ESC: begin
          state_d = ST_IDLE;
          // an escaped non-reset byte goes through as plain data
          if (hub_dn_data == RESET_SYMBOL) rst_cmd  = 1'b1;
          else                             push_req = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign f_push  = ce && push_req;
  assign f_pop   = ce && data_dwn_valid && data_dwn_ready;
  assign f_flush = ce && rst_cmd;
  assign drop    = f_push && f_full && !f_pop;

  iurt_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .pop   (f_pop),
    .flush (f_flush),
    .din   (hub_dn_data),
    .dout  (data_dwn),
    .empty (f_empty),
    .full  (f_full),
    .level (fill_level)
  );

  assign data_dwn_valid = !f_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reset_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (ce) begin
      reset_o <= rst_cmd;
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef IURT_BRIDGE_OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          ovf_count <= '0;
    else if (drop && ovf_count != '1)  ovf_count <= ovf_count + 1'b1;
  end
`endif

  // up slice: refill in the same cycle the hub drains it
  assign data_up_ready = !up_q.vld || hub_up_ready;
  assign hub_up_valid  = up_q.vld;
  assign hub_up_data   = up_q.data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q <= '0;
    end else if (ce) begin
      if (data_up_valid && data_up_ready) up_q <= '{vld: 1'b1, data: data_up};
      else if (hub_up_ready)              up_q.vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iurt_hub_bridge.sv
// Bench for iurt_hub_bridge: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_iurt_hub_bridge;
  logic       clk = 0, rst = 0, ce = 1;
  logic       hub_dn_valid = 0, hub_up_ready = 0, data_dwn_ready = 0, data_up_valid = 0;
  logic [7:0] hub_dn_data = 0, data_up = 0;
  logic       hub_up_valid, data_dwn_valid, data_up_ready, reset_o, overflow_o;
  logic [7:0] hub_up_data, data_dwn;
  logic [4:0] fill_level;
`ifdef IURT_BRIDGE_OVF_COUNT_EN
  logic [15:0] ovf_count;
  int          m_cnt;
`endif

  int total = 0, bad = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] dut_rx[$];
  bit         m_esc, m_ovf, m_rp, m_uv;
  logic [7:0] m_ud;

  iurt_hub_bridge #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hub_dn_valid(hub_dn_valid), .hub_dn_data(hub_dn_data),
    .hub_up_ready(hub_up_ready), .hub_up_valid(hub_up_valid), .hub_up_data(hub_up_data),
    .data_dwn_ready(data_dwn_ready), .data_dwn_valid(data_dwn_valid), .data_dwn(data_dwn),
    .data_up_valid(data_up_valid), .data_up(data_up), .data_up_ready(data_up_ready),
    .reset_o(reset_o), .overflow_o(overflow_o), .fill_level(fill_level)
`ifdef IURT_BRIDGE_OVF_COUNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Inputs only change at posedge+1, so at negedge they equal what the next edge samples:
  // compare the current model outputs, then advance the model through that edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mq.delete(); m_esc = 0; m_ovf = 0; m_rp = 0; m_uv = 0; m_ud = 0;
`ifdef IURT_BRIDGE_OVF_COUNT_EN
      m_cnt = 0;
`endif
    end else begin
      chk("dwn_valid", {31'd0, data_dwn_valid}, {31'd0, mq.size() != 0});
      chk("dwn_data", {24'd0, data_dwn}, mq.size() != 0 ? {24'd0, mq[0]} : 32'd0);
      chk("fill_level", {27'd0, fill_level}, mq.size());
      chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
      chk("reset_o", {31'd0, reset_o}, {31'd0, m_rp});
      chk("up_valid", {31'd0, hub_up_valid}, {31'd0, m_uv});
      chk("up_data", {24'd0, hub_up_data}, {24'd0, m_ud});
      chk("up_ready", {31'd0, data_up_ready}, {31'd0, !m_uv || hub_up_ready});
`ifdef IURT_BRIDGE_OVF_COUNT_EN
      chk("ovf_count", {16'd0, ovf_count}, m_cnt);
`endif
      if (ce && hub_up_valid && hub_up_ready) dut_rx.push_back(hub_up_data);
      if (ce) begin
        bit pop, push, flush;
        pop = (mq.size() != 0) && data_dwn_ready;
        push = 0; flush = 0;
        if (hub_dn_valid) begin
          if (m_esc) begin
            m_esc = 0;
            if (hub_dn_data == 8'hEE) flush = 1; else push = 1;
          end else if (hub_dn_data == 8'h55) m_esc = 1;
          else push = 1;
        end
        m_rp = flush;
        if (flush) mq.delete();
        else begin
          if (pop) void'(mq.pop_front());
          if (push) begin
            if (mq.size() < 16) mq.push_back(hub_dn_data);
            else begin
              m_ovf = 1;
`ifdef IURT_BRIDGE_OVF_COUNT_EN
              if (m_cnt != 32'hFFFF) m_cnt++;
`endif
            end
          end
        end
        if (data_up_valid && (!m_uv || hub_up_ready)) begin m_uv = 1; m_ud = data_up; end
        else if (hub_up_ready) m_uv = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic hub(input logic [7:0] b);
    hub_dn_valid = 1; hub_dn_data = b;
    step();
    hub_dn_valid = 0;
  endtask

  initial begin
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   k, cyc;
    logic acc;

    step(); step();
    chk("rst_fill", {27'd0, fill_level}, 0);
    chk("rst_up_ready", {31'd0, data_up_ready}, 1);
    chk("rst_up_valid", {31'd0, hub_up_valid}, 0);
    chk("rst_dwn_data", {24'd0, data_dwn}, 0);
    rst = 1;
    step();

    // single byte, 1-cycle latency, one-cycle valid with ready=1
    data_dwn_ready = 1;
    hub(8'h42);
    chk("b42_valid", {31'd0, data_dwn_valid}, 1);
    chk("b42_data", {24'd0, data_dwn}, 32'h42);
    step();
    chk("b42_gone", {31'd0, data_dwn_valid}, 0);

    // escape persists over idle cycles
    hub(8'h55);
    repeat (5) step();
    chk("esc_hold", {31'd0, data_dwn_valid}, 0);
    hub(8'h55);
    chk("esc55_data", {24'd0, data_dwn}, 32'h55);
    chk("esc55_fill", {27'd0, fill_level}, 1);
    step();
    hub(8'h55);
    hub(8'h10);
    chk("esc10_data", {24'd0, data_dwn}, 32'h10);
    chk("esc10_fill", {27'd0, fill_level}, 1);
    step();

    // fill to full, overflow, then push+pop when full
    data_dwn_ready = 0;
    for (int i = 0; i < 16; i++) hub(8'(i));
    chk("full_fill", {27'd0, fill_level}, 16);
    hub(8'h20);
    chk("ovf_fill", {27'd0, fill_level}, 16);
    chk("ovf_flag", {31'd0, overflow_o}, 1);
`ifdef IURT_BRIDGE_OVF_COUNT_EN
    chk("ovf_cnt1", {16'd0, ovf_count}, 1);
`endif
    data_dwn_ready = 1;
    hub(8'h21);
    chk("pushpop_fill", {27'd0, fill_level}, 16);
    chk("pushpop_head", {24'd0, data_dwn}, 32'h01);
    repeat (13) step();
    data_dwn_ready = 0;
    chk("drain_fill", {27'd0, fill_level}, 3);

    // reset command flushes but keeps overflow
    hub(8'h55);
    hub(8'hEE);
    chk("rcmd_pulse", {31'd0, reset_o}, 1);
    chk("rcmd_fill", {27'd0, fill_level}, 0);
    chk("rcmd_valid", {31'd0, data_dwn_valid}, 0);
    chk("rcmd_ovf", {31'd0, overflow_o}, 1);
    step();
    chk("rcmd_end", {31'd0, reset_o}, 0);

    // up stream with hub_up_ready 1,0,1,1
    dut_rx.delete();
    k = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      data_up_valid = 1; data_up = 8'hA0 + 8'(k);
      hub_up_ready = (cyc < 4) ? pat[cyc] : 1'b1;
      #1; acc = data_up_ready;
      step();
      if (acc) k++;
      cyc++;
    end
    chk("up_loaded", k, 4);
    data_up_valid = 0; hub_up_ready = 1;
    repeat (3) step();
    chk("up_rx_cnt", dut_rx.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("up_rx_byte", (i < dut_rx.size()) ? {24'd0, dut_rx[i]} : 32'hFFFF, 32'hA0 + i);

    // async reset while in ESC drops the pending escape
    hub(8'h55);
    #2 rst = 0;
    step();
    rst = 1;
    chk("rst_ovf_clr", {31'd0, overflow_o}, 0);
    hub(8'hEE);
    chk("postrst_pulse", {31'd0, reset_o}, 0);
    chk("postrst_data", {24'd0, data_dwn}, 32'hEE);
    chk("postrst_fill", {27'd0, fill_level}, 1);

    // randomized traffic, model compares every cycle
    for (int i = 0; i < 3000; i++) begin
      ce             = ($urandom_range(9) != 0);
      hub_dn_valid   = $urandom_range(1);
      case ($urandom_range(3))
        0:       hub_dn_data = 8'h55;
        1:       hub_dn_data = 8'hEE;
        default: hub_dn_data = 8'($urandom);
      endcase
      data_dwn_ready = ($urandom_range(3) == 0);
      data_up_valid  = $urandom_range(1);
      data_up        = 8'($urandom);
      hub_up_ready   = $urandom_range(1);
      step();
    end
    ce = 1; hub_dn_valid = 0; data_up_valid = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iurt_hub_bridge.md
# iurt_hub_bridge

Downstream-side bridge between the IPDBG JTAG-hub channel and `IurtController`. Decodes the hub's escape protocol on host-to-target bytes, buffers the decoded bytes in a small FIFO, and presents them on the controller's `data_dwn` valid/ready port. Registers the controller's `data_up` stream back to the hub through a one-entry register slice. It therefore sits directly upstream of the controller's down path and downstream of its up path.

## Interface
- `ADDR_WIDTH`, 4: FIFO depth is 2^ADDR_WIDTH bytes (16).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `ce`  in  1  clock enable; no state changes when 0.
- `hub_dn_valid`  in  1  hub byte strobe; valid-only, no backpressure.
- `hub_dn_data`  in  8  hub byte.
- `hub_up_ready`  in  1  hub accepts an up byte.
- `hub_up_valid`  out  1  up byte available to hub.
- `hub_up_data`  out  8  up byte to hub.
- `data_dwn_ready`  in  1  controller accepts a down byte.
- `data_dwn_valid`  out  1  FIFO not empty.
- `data_dwn`  out  8  FIFO head byte (first-word-fall-through).
- `data_up_valid`  in  1  controller up byte valid.
- `data_up`  in  8  controller up byte.
- `data_up_ready`  out  1  slice can take a byte.
- `reset_o`  out  1  one-cycle pulse on decoded reset command.
- `overflow_o`  out  1  sticky: a byte was dropped because the FIFO was full.
- `fill_level`  out  ADDR_WIDTH+1  current FIFO occupancy, 0..2^ADDR_WIDTH.

## Operation
- Escape FSM states: IDLE, ESC. Transitions happen only on `ce && hub_dn_valid`.
  - IDLE, byte 0x55 -> ESC, nothing pushed.
  - IDLE, any other byte -> push the byte.
  - ESC, 0x55 -> push 0x55, go to IDLE.
  - ESC, 0xEE -> pulse `reset_o`, flush the FIFO, go to IDLE.
  - ESC, any other byte -> push the byte, go to IDLE (the escape is discarded).
- ESC persists across any number of cycles without `hub_dn_valid`.
- FIFO:
  - Pop on `ce && data_dwn_valid && data_dwn_ready`.
  - A push when full is dropped and sets `overflow_o`, except when a pop happens in the same cycle; then the push is accepted and the count is unchanged.
  - Pointers wrap modulo 2^ADDR_WIDTH. `fill_level` is an (ADDR_WIDTH+1)-bit count.
- Flush clears both pointers and `fill_level`. It does not clear `overflow_o`. A pop in the flush cycle is ignored.
- Up slice:
  - `data_up_ready = !full_q || hub_up_ready`.
  - Load on `ce && data_up_valid && data_up_ready`.
  - Clear `full_q` on `ce && hub_up_ready` when not loading.
  - `hub_up_valid = full_q`.
- Reset values: FSM IDLE; FIFO empty; `data_dwn_valid` 0; `data_dwn` 0; `hub_up_valid` 0; `hub_up_data` 0; `data_up_ready` 1; `reset_o` 0; `overflow_o` 0; `fill_level` 0.
- Reset is asynchronous and can assert at any point, including mid-escape; the FSM returns to IDLE and any pending ESC is lost.
- `overflow_o` clears only on `rst`.

## Timing
- Hub byte accepted at edge N: `data_dwn_valid`=1 and `data_dwn` = byte after edge N (1-cycle latency).
- `reset_o`: high for exactly the one cycle following the edge that accepted 0xEE in ESC. `fill_level`=0 in that same cycle.
- Up path: a byte loaded at edge N is on `hub_up_*` after edge N. Sustained throughput is 1 byte/cycle while `hub_up_ready`=1.
- With `ce`=0, every output holds its value.

## Configuration
- `IURT_BRIDGE_OVF_COUNT_EN` defined:
  - Adds output `ovf_count` (out, 16 bits), which counts dropped bytes.
  - The counter saturates at 0xFFFF, resets to 0, and is not cleared by flush.
- Macro undefined: the port and counter are absent, and `overflow_o` is the only overflow indication.

## Structure
- Package `iurt_pkg` holds `ESCAPE_SYMBOL` = 8'h55, `RESET_SYMBOL` = 8'hEE, and the `iurt_byte_t` 8-bit typedef. The package is shared with the controller and the hub side.
- Sub-module `iurt_fifo` implements the FIFO: parameter ADDR_WIDTH; ports push, pop, flush, din, dout, empty, full, level. The escape FSM and up slice stay in the top module.

## Test plan
- Hub sends 0x42, controller ready=1 -> `data_dwn_valid` is high for one cycle, 1 cycle later, with `data_dwn`=0x42.
- Hub sends 0x55, idles 5 cycles, then sends 0x55 -> exactly one 0x55 is delivered. Hub sends 0x55, 0x10 -> only 0x10 is delivered.
- Fill 16 bytes with `data_dwn_ready`=0, then push a 17th -> `fill_level`=16 and `overflow_o`=1; with the macro, `ovf_count`=1. Next push with a simultaneous pop -> accepted, `fill_level` stays 16.
- With 3 bytes queued, hub sends 0x55, 0xEE -> `reset_o` pulses for 1 cycle, `fill_level`=0, `data_dwn_valid`=0, and `overflow_o` is unchanged.
- Controller streams 0xA0..0xA3 with `hub_up_ready` toggling 1,0,1,1 -> the hub receives all four bytes in order with none lost or duplicated, and `data_up_ready` drops only while the slice is full and `hub_up_ready`=0.
- Assert `rst` while in ESC, then send 0xEE -> 0xEE is pushed as a data byte and `reset_o` stays 0.
